// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite blitter (colour type, key colour, FSM states).
// Optional colour keying is enabled by defining SPRITE_TRANSPARENT_KEY_EN.
package sprite_pkg;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t KEY_COLOR    = 16'hFFFF;
  localparam int      DEF_SCREEN_W = 320;
  localparam int      DEF_SCREEN_H = 240;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WRITE,
    DONE
  } blit_state_e;

endpackage

// File: rtl/sprite_blitter_if.sv
// Framebuffer write port: blitter is master, framebuffer is slave (valid/ready).
interface sprite_blitter_if
  import sprite_pkg::*;
#(
  parameter int FB_AW = 17
) ();

  logic             fb_valid;
  logic             fb_ready;
  logic [FB_AW-1:0] fb_addr;
  rgb565_t          fb_data;

  modport master (output fb_valid, output fb_addr, output fb_data, input fb_ready);
  modport slave  (input fb_valid, input fb_addr, input fb_data, output fb_ready);

endinterface

// File: rtl/blit_clip.sv
// Screen-space position, on-screen test and framebuffer address for one sprite pixel.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module blit_clip
  import sprite_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int FB_AW    = 17
) (
  input  logic signed [9:0] pos_x,
  input  logic signed [9:0] pos_y,
  input  logic        [8:0] col,
  input  logic        [8:0] row,
  output logic              on_screen,
  output logic [FB_AW-1:0]  addr
);

  localparam logic [10:0] SW = 11'(SCREEN_W);
  localparam logic [10:0] SH = 11'(SCREEN_H);

  logic [10:0] sx;
  logic [10:0] sy;

  // 11 bits holds pos (-512..511) plus offset (0..511) without overflow.
  assign sx = {pos_x[9], pos_x} + {2'b00, col};
  assign sy = {pos_y[9], pos_y} + {2'b00, row};

  assign on_screen = !sx[10] && !sy[10] && (sx < SW) && (sy < SH);

  // Only meaningful when on_screen; the product wraps modulo 2^FB_AW.
  assign addr = FB_AW'(sy[9:0]) * FB_AW'(SCREEN_W) + FB_AW'(sx[9:0]);

endmodule

// File: rtl/sprite_blitter.sv
// Copies a ROM sprite to the framebuffer at a signed position, clipping (and keying if SPRITE_TRANSPARENT_KEY_EN).
// Latency: 1 cycle per skipped pixel, 2 per written pixel with ready high, +1 cycle DONE.
// Backpressure: fb_valid/addr/data held stable in WRITE until fb_ready; start ignored while busy.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int PIX_AW   = 17,
  parameter int FB_AW    = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [9:0]  pos_x,
  input  logic signed [9:0]  pos_y,
  input  logic        [8:0]  spr_width,
  input  logic        [8:0]  spr_height,
  output logic [PIX_AW-1:0]  spr_pixel,
  input  rgb565_t            spr_color,
  output logic               busy,
  output logic               done,
  sprite_blitter_if.master   fb
);

  blit_state_e       state;
  logic signed [9:0] px_r;
  logic signed [9:0] py_r;
  logic [8:0]        w_r;
  logic [8:0]        h_r;
  logic [8:0]        row;
  logic [8:0]        col;
  logic [8:0]        row_nxt;
  logic [8:0]        col_nxt;
  logic              last_col;
  logic              last_pix;
  logic              on_screen;
  logic              keyed;
  logic              visible;
  logic [FB_AW-1:0]  clip_addr;
  logic              fb_valid_r;
  logic [FB_AW-1:0]  fb_addr_r;
  rgb565_t           fb_data_r;

  blit_clip #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .FB_AW    (FB_AW)
  ) u_clip (
    .pos_x     (px_r),
    .pos_y     (py_r),
    .col       (col),
    .row       (row),
    .on_screen (on_screen),
    .addr      (clip_addr)
  );

`ifdef SPRITE_TRANSPARENT_KEY_EN
  assign keyed = (spr_color == KEY_COLOR);
`else
  assign keyed = 1'b0;
`endif

  assign visible  = on_screen && !keyed;
  assign last_col = (col == w_r - 9'd1);
  assign last_pix = last_col && (row == h_r - 9'd1);

  always_comb begin
    col_nxt = col + 9'd1;
    row_nxt = row;
    if (last_col) begin
      col_nxt = '0;
      row_nxt = row + 9'd1;
    end
  end

  assign fb.fb_valid = fb_valid_r;
  assign fb.fb_addr  = fb_addr_r;
  assign fb.fb_data  = fb_data_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      px_r       <= '0;
      py_r       <= '0;
      w_r        <= '0;
      h_r        <= '0;
      row        <= '0;
      col        <= '0;
      spr_pixel  <= '0;
      fb_valid_r <= 1'b0;
      fb_addr_r  <= '0;
      fb_data_r  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            px_r      <= pos_x;
            py_r      <= pos_y;
            w_r       <= spr_width;
            h_r       <= spr_height;
            row       <= '0;
            col       <= '0;
            spr_pixel <= '0;
            busy      <= 1'b1;
            if (spr_width == 9'd0 || spr_height == 9'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          // spr_color is valid now because spr_pixel was registered last cycle.
          if (visible) begin
            fb_addr_r  <= clip_addr;
            fb_data_r  <= spr_color;
            fb_valid_r <= 1'b1;
            state      <= WRITE;
          end else if (last_pix) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            col       <= col_nxt;
            row       <= row_nxt;
            spr_pixel <= spr_pixel + PIX_AW'(1);
          end
        end
        WRITE: begin
          if (fb.fb_ready) begin
            fb_valid_r <= 1'b0;
            if (last_pix) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              col       <= col_nxt;
              row       <= row_nxt;
              spr_pixel <= spr_pixel + PIX_AW'(1);
              state     <= FETCH;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter; expectations follow SPRITE_TRANSPARENT_KEY_EN when it is defined.
module tb_sprite_blitter;
  import sprite_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic signed [9:0] pos_x = '0;
  logic signed [9:0] pos_y = '0;
  logic [8:0]        spr_width = '0;
  logic [8:0]        spr_height = '0;
  logic [16:0]       spr_pixel;
  rgb565_t           spr_color;
  logic              busy;
  logic              done;

  sprite_blitter_if #(.FB_AW(17)) fb ();

  sprite_blitter #(
    .SCREEN_W (320),
    .SCREEN_H (240),
    .PIX_AW   (17),
    .FB_AW    (17)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .spr_width  (spr_width),
    .spr_height (spr_height),
    .spr_pixel  (spr_pixel),
    .spr_color  (spr_color),
    .busy       (busy),
    .done       (done),
    .fb         (fb)
  );

  logic [15:0] rom [0:1023];
  assign spr_color = (spr_pixel < 17'd1024) ? rom[spr_pixel[9:0]] : 16'h0000;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int t0 = 0;
  int wr_base = 0;
  int done_base = 0;

  logic [16:0] wr_addr [$];
  logic [15:0] wr_data [$];
  int          wr_cyc  [$];
  int          done_cnt = 0;
  int          hold_err = 0;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_addr = '0;
  logic [15:0] prev_data = '0;

  // Mid-cycle observer: accepted writes, done pulses, and stall stability.
  always @(negedge clk) begin
    if (fb.fb_valid && fb.fb_ready) begin
      wr_addr.push_back(fb.fb_addr);
      wr_data.push_back(fb.fb_data);
      wr_cyc.push_back(cyc - t0);
    end
    if (done) done_cnt++;
    if (prev_stall && rst_n &&
        (!fb.fb_valid || fb.fb_addr !== prev_addr || fb.fb_data !== prev_data))
      hold_err++;
    prev_stall = rst_n && fb.fb_valid && !fb.fb_ready;
    prev_addr  = fb.fb_addr;
    prev_data  = fb.fb_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int x, input int y, input int w, input int h);
    wr_base    = wr_addr.size();
    done_base  = done_cnt;
    pos_x      = 10'(x);
    pos_y      = 10'(y);
    spr_width  = 9'(w);
    spr_height = 9'(h);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0    = cyc - 1;
  endtask

  task automatic wait_done(input int bound, output int at);
    int k;
    k = 0;
    while (!done && k < bound) begin
      step();
      k++;
    end
    chk("done_timeout", {31'd0, done}, 32'd1);
    at = cyc - t0;
  endtask

  task automatic chk_wr(input string tag, input int idx, input int addr, input int data, input int c);
    if (wr_addr.size() > wr_base + idx) begin
      chk({tag, "_addr"}, 32'(wr_addr[wr_base+idx]), addr);
      chk({tag, "_data"}, 32'(wr_data[wr_base+idx]), data);
      if (c >= 0) chk({tag, "_cyc"}, wr_cyc[wr_base+idx], c);
    end else begin
      chk({tag, "_missing"}, wr_addr.size() - wr_base, idx + 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int stall_bad;
    int e_addr [4];
    int e_data [4];
    e_addr = '{0, 1, 320, 321};
    e_data = '{32'hA0A0, 32'hB1B1, 32'hC2C2, 32'hD3D3};

    for (int i = 0; i < 1024; i++) rom[i] = 16'(16'h1000 + i);
    fb.fb_ready = 1'b1;

    // Reset values
    step(2);
    chk("rst_pixel", 32'(spr_pixel), 0);
    chk("rst_valid", {31'd0, fb.fb_valid}, 0);
    chk("rst_addr", 32'(fb.fb_addr), 0);
    chk("rst_data", 32'(fb.fb_data), 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    rst_n = 1'b1;
    step(2);

    // 2x2 at (0,0), ready always high
    for (int i = 0; i < 4; i++) rom[i] = 16'(e_data[i]);
    do_start(0, 0, 2, 2);
    chk("t1_busy_c1", {31'd0, busy}, 1);
    wait_done(40, d);
    chk("t1_done_cyc", d, 9);
    step();
    chk("t1_busy_c10", {31'd0, busy}, 0);
    chk("t1_nwr", wr_addr.size() - wr_base, 4);
    for (int i = 0; i < 4; i++)
      chk_wr($sformatf("t1_wr%0d", i), i, e_addr[i], e_data[i], 2 + 2 * i);

    // Same blit, first write stalled for 5 cycles
    fb.fb_ready = 1'b0;
    do_start(0, 0, 2, 2);
    stall_bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!(fb.fb_valid === 1'b1 && fb.fb_addr === 17'd0 && fb.fb_data === 16'hA0A0))
        stall_bad++;
    end
    chk("t2_stall_stable", stall_bad, 0);
    step();
    fb.fb_ready = 1'b1;
    wait_done(40, d);
    chk("t2_done_cyc", d, 14);
    step();
    chk("t2_nwr", wr_addr.size() - wr_base, 4);
    chk("t2_ndone", done_cnt - done_base, 1);
    chk_wr("t2_wr0", 0, 0, 32'hA0A0, 7);
    chk_wr("t2_wr3", 3, 321, 32'hD3D3, 13);

    // 29x32 at (-10,230): clipped on left and bottom
    for (int i = 0; i < 1024; i++) rom[i] = 16'(16'h1000 + i);
    do_start(-10, 230, 29, 32);
    wait_done(1500, d);
    chk("t3_done_cyc", d, 1119);
    step();
    chk("t3_nwr", wr_addr.size() - wr_base, 190);
    chk_wr("t3_first", 0, 73600, 32'h100A, 12);
    chk_wr("t3_last", 189, 76498, 32'h1121, -1);

    // 3-wide single row with key-colour pixels at (5,0)
    rom[0] = 16'hFFFF;
    rom[1] = 16'h2082;
    rom[2] = 16'hFFFF;
    do_start(5, 0, 3, 1);
    wait_done(40, d);
    step();
`ifdef SPRITE_TRANSPARENT_KEY_EN
    chk("t4_done_cyc", d, 5);
    chk("t4_nwr", wr_addr.size() - wr_base, 1);
    chk_wr("t4_wr0", 0, 6, 32'h2082, 3);
`else
    chk("t4_done_cyc", d, 7);
    chk("t4_nwr", wr_addr.size() - wr_base, 3);
    chk_wr("t4_wr0", 0, 5, 32'hFFFF, 2);
    chk_wr("t4_wr1", 1, 6, 32'h2082, 4);
    chk_wr("t4_wr2", 2, 7, 32'hFFFF, 6);
`endif

    // Zero width finishes immediately
    do_start(0, 0, 0, 5);
    chk("t5_done_c1", {31'd0, done}, 1);
    step();
    chk("t5_busy_c2", {31'd0, busy}, 0);
    chk("t5_nwr", wr_addr.size() - wr_base, 0);

    // start while busy is ignored
    for (int i = 0; i < 4; i++) rom[i] = 16'(e_data[i]);
    do_start(0, 0, 2, 2);
    step(2);
    start = 1'b1;
    pos_x = 10'd100;
    step();
    start = 1'b0;
    wait_done(40, d);
    chk("t5b_done_cyc", d, 9);
    step(10);
    chk("t5b_ndone", done_cnt - done_base, 1);
    chk("t5b_nwr", wr_addr.size() - wr_base, 4);
    chk("t5b_busy", {31'd0, busy}, 0);
    chk_wr("t5b_wr3", 3, 321, 32'hD3D3, 8);

    // Async reset during a stalled WRITE of a 4x4 blit
    for (int i = 0; i < 16; i++) rom[i] = 16'(16'h1000 + i);
    fb.fb_ready = 1'b0;
    do_start(0, 0, 4, 4);
    step();
    chk("t6_valid_pre", {31'd0, fb.fb_valid}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid_rst", {31'd0, fb.fb_valid}, 0);
    chk("t6_busy_rst", {31'd0, busy}, 0);
    step(3);
    rst_n = 1'b1;
    fb.fb_ready = 1'b1;
    step(5);
    chk("t6_ndone", done_cnt - done_base, 0);
    chk("t6_nwr", wr_addr.size() - wr_base, 0);
    do_start(0, 0, 4, 4);
    wait_done(100, d);
    chk("t6_done_cyc", d, 33);
    step();
    chk("t6_nwr2", wr_addr.size() - wr_base, 16);
    chk_wr("t6_first", 0, 0, 32'h1000, 2);
    chk_wr("t6_last", 15, 963, 32'h100F, 32);

    chk("hold_protocol", hold_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
